// File: rtl/thermometer_pkg.sv
// Shared thermometer-code helpers used by the thermometer encoder and decoder.
// Vectors are passed zero-extended to THERM_MAX_W with the live width alongside.
package thermometer_pkg;

   localparam int unsigned THERM_MAX_W = 256;

   typedef logic [THERM_MAX_W-1:0] therm_vec_t;

   function automatic int unsigned thermometer_bw(input int unsigned width);
      return $clog2(width + 1);
   endfunction

   // Legal means no 1 appears above the lowest 0.
   function automatic logic thermometer_legal(input therm_vec_t v, input int unsigned width);
      logic seen_zero;
      logic legal;
      seen_zero = 1'b0;
      legal     = 1'b1;
      for (int unsigned i = 0; i < THERM_MAX_W; i++) begin
         if (i < width) begin
            if (!v[i]) begin
               seen_zero = 1'b1;
            end else if (seen_zero) begin
               legal = 1'b0;
            end
         end
      end
      return legal;
   endfunction

   // Length of the run of 1s starting at bit 0 (index of the lowest 0, or width).
   function automatic int unsigned thermometer_count(input therm_vec_t v, input int unsigned width);
      logic        run;
      int unsigned n;
      run = 1'b1;
      n   = 0;
      for (int unsigned i = 0; i < THERM_MAX_W; i++) begin
         if (i < width) begin
            if (!v[i]) begin
               run = 1'b0;
            end else if (run) begin
               n++;
            end
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/thermometer2binary_pipe_stage.sv
// One elastic pipeline slot: valid bit, data register and its load enable.
// en_o is combinational so a full pipe can still advance when downstream drains.
module pipe_stage #(
   parameter int unsigned DW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid_i,
   input  logic [DW-1:0] up_data_i,
   input  logic          dn_en_i,
   output logic          en_o,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   assign en_o    = !valid_q || dn_en_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (en_o) begin
         valid_d = up_valid_i;
         if (up_valid_i) begin
            data_d = up_data_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/thermometer2binary.sv
// Two-stage registered thermometer-to-binary decoder with saturating error count.
// Define THERMOMETER2BINARY_BUBBLE_CORRECT_EN to majority-filter single-bit bubbles.
module thermometer2binary
   import thermometer_pkg::*;
#(
   parameter  int unsigned WIDTH     = 4,
   parameter  int unsigned CNT_WIDTH = 8,
   localparam int unsigned BW        = thermometer_bw(WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [WIDTH-1:0]     s_thermometer,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [BW-1:0]        m_binary,
   output logic                 m_error,
   input  logic                 err_clr,
   output logic [CNT_WIDTH-1:0] err_cnt
);

   logic             en1, en2;
   logic             v1, v2;
   logic             err_in;
   logic [WIDTH-1:0] t_in;
   therm_vec_t       raw_ext;
   logic [WIDTH:0]   st1_data;
   logic             err1;
   logic [WIDTH-1:0] t1;
   therm_vec_t       t1_ext;
   logic [BW-1:0]    bin_in;
   logic [BW:0]      st2_data;

   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

`ifdef THERMOMETER2BINARY_BUBBLE_CORRECT_EN
   // Padded with the virtual bits r[-1]=1 (bit 0) and r[WIDTH]=0 (top bit).
   logic [WIDTH+1:0] r_pad;
   assign r_pad = {1'b0, s_thermometer, 1'b1};
`endif

   always_comb begin
      raw_ext                = '0;
      raw_ext[WIDTH-1:0]     = s_thermometer;
      err_in                 = !thermometer_legal(raw_ext, WIDTH);
`ifdef THERMOMETER2BINARY_BUBBLE_CORRECT_EN
      t_in = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         t_in[i] = (r_pad[i] & r_pad[i+1]) | (r_pad[i] & r_pad[i+2]) | (r_pad[i+1] & r_pad[i+2]);
      end
`else
      t_in = s_thermometer;
`endif
   end

   pipe_stage #(
      .DW(WIDTH + 1)
   ) u_stage1 (
      .clk        (clk),
      .rst        (rst),
      .up_valid_i (s_valid),
      .up_data_i  ({err_in, t_in}),
      .dn_en_i    (en2),
      .en_o       (en1),
      .valid_o    (v1),
      .data_o     (st1_data)
   );

   assign err1 = st1_data[WIDTH];
   assign t1   = st1_data[WIDTH-1:0];

   always_comb begin
      t1_ext            = '0;
      t1_ext[WIDTH-1:0] = t1;
      bin_in            = BW'(thermometer_count(t1_ext, WIDTH));
   end

   pipe_stage #(
      .DW(BW + 1)
   ) u_stage2 (
      .clk        (clk),
      .rst        (rst),
      .up_valid_i (v1),
      .up_data_i  ({err1, bin_in}),
      .dn_en_i    (m_ready),
      .en_o       (en2),
      .valid_o    (v2),
      .data_o     (st2_data)
   );

   assign s_ready  = en1;
   assign m_valid  = v2;
   assign m_error  = st2_data[BW];
   assign m_binary = st2_data[BW-1:0];

   // Clear takes priority over an increment in the same cycle.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = '0;
      end else if (v2 && m_ready && m_error && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_thermometer2binary.sv
// Scoreboard bench for thermometer2binary (WIDTH=4) plus a CNT_WIDTH=2 instance for saturation.
module tb_thermometer2binary;

   typedef struct packed {
      logic [2:0] bin;
      logic       err;
   } exp_t;

   // Hand-computed per-code results, index = 4-bit input code.
   localparam logic [2:0] RAW_CNT [16] = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd3,
                                          3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd4};
   localparam logic [2:0] BC_CNT  [16] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd0, 3'd2, 3'd3, 3'd3,
                                          3'd0, 3'd1, 3'd1, 3'd3, 3'd0, 3'd4, 3'd4, 3'd4};
   localparam logic [15:0] ERR_TAB = 16'h7F74;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_valid = 1'b0;
   logic       s_ready;
   logic [3:0] s_therm = '0;
   logic       m_valid;
   logic       m_ready = 1'b0;
   logic [2:0] m_bin;
   logic       m_err;
   logic       err_clr = 1'b0;
   logic [7:0] err_cnt;

   logic       s2_valid = 1'b0;
   logic       s2_ready;
   logic [3:0] s2_therm = '0;
   logic       m2_valid;
   logic       m2_ready = 1'b1;
   logic [2:0] m2_bin;
   logic       m2_err;
   logic       clr2 = 1'b0;
   logic [1:0] cnt2;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_acc = 0;
   int   model_cnt = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   thermometer2binary #(.WIDTH(4), .CNT_WIDTH(8)) u_dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_thermometer(s_therm),
      .m_valid(m_valid), .m_ready(m_ready), .m_binary(m_bin), .m_error(m_err),
      .err_clr(err_clr), .err_cnt(err_cnt)
   );

   thermometer2binary #(.WIDTH(4), .CNT_WIDTH(2)) u_sat (
      .clk(clk), .rst(rst), .s_valid(s2_valid), .s_ready(s2_ready), .s_thermometer(s2_therm),
      .m_valid(m2_valid), .m_ready(m2_ready), .m_binary(m2_bin), .m_error(m2_err),
      .err_clr(clr2), .err_cnt(cnt2)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t expect_of(input logic [3:0] c);
      exp_t e;
`ifdef THERMOMETER2BINARY_BUBBLE_CORRECT_EN
      e.bin = BC_CNT[c];
`else
      e.bin = RAW_CNT[c];
`endif
      e.err = ERR_TAB[c];
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      m_ready = 1'b1;
      s_valid = 1'b0;
      for (int i = 0; i < 100 && q.size() != 0; i++) tick();
      tick();
      check("drain_empty", q.size(), 0);
   endtask

   // Input side: record every accepted word.
   always @(negedge clk) begin
      if (!rst && s_valid && s_ready) begin
         q.push_back(expect_of(s_therm));
         n_acc++;
      end
   end

   // Output side: compare presented words and track the expected error counter.
   always @(negedge clk) begin
      exp_t e;
      logic xfer_err;
      xfer_err = 1'b0;
      if (rst) model_cnt = 0;
      check("err_cnt", err_cnt, model_cnt);
      if (!rst && m_valid) begin
         check("out_pending", int'(q.size() != 0), 1);
         if (q.size() != 0) begin
            e = q[0];
            check("m_binary", m_bin, e.bin);
            check("m_error", m_err, e.err);
            if (m_ready) begin
               void'(q.pop_front());
               xfer_err = e.err;
            end
         end
      end
      if (!rst) begin
         if (err_clr) model_cnt = 0;
         else if (xfer_err && model_cnt < 255) model_cnt++;
      end
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      int   n0;
      logic [3:0] stall_codes [5];
      logic [3:0] rel_codes [4];
      stall_codes = '{4'b0001, 4'b0011, 4'b0110, 4'b1111, 4'b1001};
      rel_codes   = '{4'b0111, 4'b1101, 4'b0000, 4'b1011};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_s_ready", s_ready, 1);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_binary", m_bin, 0);
      check("rst_m_error", m_err, 0);
      check("rst_cnt2", cnt2, 0);
      check("rst_s2_ready", s2_ready, 1);
      tick();
      rst = 1'b0;

      // Back-to-back legal codes, latency and throughput
      m_ready = 1'b1;
      tick();
      s_valid = 1'b1; s_therm = 4'b0000;
      tick();
      s_therm = 4'b0111;
      @(negedge clk); check("lat_edge1", m_valid, 0);
      tick();
      s_therm = 4'b1111;
      @(negedge clk); check("lat_edge2", m_valid, 1);
      tick();
      s_valid = 1'b0;
      @(negedge clk); check("tput_edge3", m_valid, 1);
      tick();
      @(negedge clk); check("tput_edge4", m_valid, 1);
      tick();
      @(negedge clk); check("tput_edge5", m_valid, 0);

      // Single bubble code
      tick();
      s_valid = 1'b1; s_therm = 4'b0101;
      tick();
      s_valid = 1'b0;
      repeat (4) tick();
      check("err_cnt_after_0101", err_cnt, 1);

      // Stall with continuous input
      m_ready = 1'b0;
      s_valid = 1'b1;
      n0 = n_acc;
      for (int i = 0; i < 5; i++) begin
         s_therm = stall_codes[i];
         tick();
      end
      @(negedge clk);
      check("stall_s_ready", s_ready, 0);
      check("stall_m_valid", m_valid, 1);
      check("stall_buffered", n_acc - n0, 2);
      tick();
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_therm = rel_codes[i];
         tick();
      end
      drain();

      // Random handshakes over all codes
      for (int i = 0; i < 10000; i++) begin
         s_valid = 1'($urandom_range(0, 1));
         m_ready = 1'($urandom_range(0, 1));
         s_therm = 4'($urandom_range(0, 15));
         err_clr = ($urandom_range(0, 63) == 0);
         tick();
      end
      err_clr = 1'b0;
      drain();

      // Saturation on the 2-bit counter instance
      s2_valid = 1'b1; s2_therm = 4'b0101;
      repeat (5) tick();
      s2_valid = 1'b0;
      repeat (4) tick();
      check("sat_cnt", cnt2, 3);
      s2_valid = 1'b1; s2_therm = 4'b1000;
      tick();
      s2_valid = 1'b0;
      tick();
      check("sat_clr_mvalid", m2_valid, 1);
      check("sat_clr_merr", m2_err, 1);
      check("sat_clr_mbin", m2_bin, RAW_CNT[8]);
      clr2 = 1'b1;
      tick();
      clr2 = 1'b0;
      check("sat_clr_cnt", cnt2, 0);
      tick();
      check("sat_clr_hold", cnt2, 0);

      // Reset while both stages hold words
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      s_valid = 1'b1; s_therm = 4'b1011;
      tick();
      s_valid = 1'b0;
      repeat (4) tick();
      check("pre_rst_err_cnt", err_cnt, 1);
      m_ready = 1'b0;
      s_valid = 1'b1; s_therm = 4'b0011;
      tick();
      s_therm = 4'b0111;
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      check("full_m_valid", m_valid, 1);
      check("full_s_ready", s_ready, 0);
      #2;
      rst = 1'b1;
      q.delete();
      #1;
      check("async_rst_m_valid", m_valid, 0);
      check("async_rst_err_cnt", err_cnt, 0);
      check("async_rst_s_ready", s_ready, 1);
      tick();
      tick();
      rst = 1'b0;
      m_ready = 1'b1;
      s_valid = 1'b1; s_therm = 4'b0011;
      tick();
      s_valid = 1'b0;
      @(negedge clk); check("post_rst_lat1", m_valid, 0);
      tick();
      @(negedge clk); check("post_rst_lat2", m_valid, 1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
